// File: rtl/complex_matched_fir_pkg.sv
// Shared types, default widths and width-growth helpers for the complex matched FIR.
package complex_fir_pkg;

    localparam int unsigned DEF_LENGTH      = 12;
    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_COEFF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_COEFF,
        ST_RUN,
        ST_FLUSH
    } fir_state_e;

    // One complex product needs one guard bit for the two-term sum.
    function automatic int unsigned fir_prod_width(input int unsigned dw, input int unsigned cw);
        return dw + cw + 1;
    endfunction

    // Full-precision accumulator: product width plus log2(LENGTH) guard bits.
    function automatic int unsigned fir_out_width(input int unsigned dw, input int unsigned cw,
                                                  input int unsigned len);
        return fir_prod_width(dw, cw) + $clog2(len);
    endfunction

endpackage

// File: rtl/complex_matched_fir_if.sv
// Streaming/coefficient-load bundle between sample source, FIR and downstream detector.
interface complex_matched_fir_if
    import complex_fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int unsigned OUT_WIDTH   = fir_out_width(DEF_DATA_WIDTH, DEF_COEFF_WIDTH, DEF_LENGTH)
) ();

    logic                          coeffLoad;
    logic                          coeffValid;
    logic signed [COEFF_WIDTH-1:0] coeffInRe;
    logic signed [COEFF_WIDTH-1:0] coeffInIm;
    logic                          conjMode;
    logic                          flush;
    logic                          dataValidIn;
    logic signed [DATA_WIDTH-1:0]  dataInRe;
    logic signed [DATA_WIDTH-1:0]  dataInIm;
    logic                          coeffSetFlag;
    logic                          busy;
    logic                          dataValidOut;
    logic signed [OUT_WIDTH-1:0]   dataOutRe;
    logic signed [OUT_WIDTH-1:0]   dataOutIm;

    modport master (
        output coeffLoad, coeffValid, coeffInRe, coeffInIm, conjMode,
               flush, dataValidIn, dataInRe, dataInIm,
        input  coeffSetFlag, busy, dataValidOut, dataOutRe, dataOutIm
    );

    modport slave (
        input  coeffLoad, coeffValid, coeffInRe, coeffInIm, conjMode,
               flush, dataValidIn, dataInRe, dataInIm,
        output coeffSetFlag, busy, dataValidOut, dataOutRe, dataOutIm
    );

endinterface

// File: rtl/complex_matched_fir_mult.sv
// Registered complex multiplier, optionally using the conjugate of the coefficient.
module complex_mult
    import complex_fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int unsigned PROD_WIDTH  = fir_prod_width(DATA_WIDTH, COEFF_WIDTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          conj,
    input  logic signed [DATA_WIDTH-1:0]  x_re,
    input  logic signed [DATA_WIDTH-1:0]  x_im,
    input  logic signed [COEFF_WIDTH-1:0] h_re,
    input  logic signed [COEFF_WIDTH-1:0] h_im,
    output logic signed [PROD_WIDTH-1:0]  p_re,
    output logic signed [PROD_WIDTH-1:0]  p_im
);

    logic signed [PROD_WIDTH-1:0] rr, ii, ri, ir;
    logic signed [PROD_WIDTH-1:0] p_re_d, p_im_d, p_re_q, p_im_q;

    always_comb begin
        rr = PROD_WIDTH'(x_re) * PROD_WIDTH'(h_re);
        ii = PROD_WIDTH'(x_im) * PROD_WIDTH'(h_im);
        ri = PROD_WIDTH'(x_re) * PROD_WIDTH'(h_im);
        ir = PROD_WIDTH'(x_im) * PROD_WIDTH'(h_re);
        if (conj) begin
            p_re_d = rr + ii;
            p_im_d = ir - ri;
        end else begin
            p_re_d = rr - ii;
            p_im_d = ri + ir;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_re_q <= '0;
            p_im_q <= '0;
        end else begin
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
        end
    end

    assign p_re = p_re_q;
    assign p_im = p_im_q;

endmodule

// File: rtl/complex_matched_fir.sv
// LENGTH-tap complex FIR with runtime coefficient load, matched (conjugate) mode and
// self-generated zero-padding flush; delay line -> product regs -> sum reg.
module complex_matched_fir
    import complex_fir_pkg::*;
#(
    parameter int unsigned LENGTH      = DEF_LENGTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int unsigned OUT_WIDTH   = fir_out_width(DATA_WIDTH, COEFF_WIDTH, LENGTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    complex_matched_fir_if.slave bus
);

    localparam int unsigned PROD_WIDTH = fir_prod_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int unsigned CNT_W      = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] IDX_LAST   = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LENGTH - 2);

    fir_state_e state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic conj_q, conj_d;
    logic flag_q, flag_d;
    logic busy_q, busy_d;
    logic vline_q, vline_d;
    logic vprod_q, vprod_d;
    logic vout_q, vout_d;

    logic signed [COEFF_WIDTH-1:0] coef_re_q [LENGTH];
    logic signed [COEFF_WIDTH-1:0] coef_im_q [LENGTH];
    logic signed [COEFF_WIDTH-1:0] coef_re_d [LENGTH];
    logic signed [COEFF_WIDTH-1:0] coef_im_d [LENGTH];
    logic signed [DATA_WIDTH-1:0]  line_re_q [LENGTH];
    logic signed [DATA_WIDTH-1:0]  line_im_q [LENGTH];
    logic signed [DATA_WIDTH-1:0]  line_re_d [LENGTH];
    logic signed [DATA_WIDTH-1:0]  line_im_d [LENGTH];
    logic signed [PROD_WIDTH-1:0]  prod_re [LENGTH];
    logic signed [PROD_WIDTH-1:0]  prod_im [LENGTH];

    logic signed [OUT_WIDTH-1:0] acc_re, acc_im;
    logic signed [OUT_WIDTH-1:0] sum_re_q, sum_im_q, sum_re_d, sum_im_d;

    logic                         shift_en, line_clear;
    logic signed [DATA_WIDTH-1:0] shift_re, shift_im;

    for (genvar k = 0; k < LENGTH; k++) begin : g_tap
        complex_mult #(
            .DATA_WIDTH (DATA_WIDTH),
            .COEFF_WIDTH(COEFF_WIDTH),
            .PROD_WIDTH (PROD_WIDTH)
        ) u_mult (
            .clock(clock),
            .reset(reset),
            .conj (conj_q),
            .x_re (line_re_q[k]),
            .x_im (line_im_q[k]),
            .h_re (coef_re_q[k]),
            .h_im (coef_im_q[k]),
            .p_re (prod_re[k]),
            .p_im (prod_im[k])
        );
    end

    always_comb begin
        acc_re = '0;
        acc_im = '0;
        for (int unsigned k = 0; k < LENGTH; k++) begin
            acc_re = acc_re + OUT_WIDTH'(prod_re[k]);
            acc_im = acc_im + OUT_WIDTH'(prod_im[k]);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        conj_d     = conj_q;
        flag_d     = flag_q;
        busy_d     = busy_q;
        coef_re_d  = coef_re_q;
        coef_im_d  = coef_im_q;
        shift_en   = 1'b0;
        shift_re   = '0;
        shift_im   = '0;
        line_clear = 1'b0;
        vline_d    = 1'b0;
        vprod_d    = vline_q;
        vout_d     = vprod_q;

        // A load request wins over everything and discards in-flight results.
        if (bus.coeffLoad) begin
            state_d = ST_LOAD_COEFF;
            idx_d   = '0;
            fcnt_d  = '0;
            flag_d  = 1'b0;
            busy_d  = 1'b1;
            vprod_d = 1'b0;
            vout_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_LOAD_COEFF: begin
                    if (bus.coeffValid) begin
                        coef_re_d[idx_q] = bus.coeffInRe;
                        coef_im_d[idx_q] = bus.coeffInIm;
                        if (idx_q == IDX_LAST) begin
                            conj_d     = bus.conjMode;
                            line_clear = 1'b1;
                            vprod_d    = 1'b0;
                            vout_d     = 1'b0;
                            flag_d     = 1'b1;
                            busy_d     = 1'b0;
                            idx_d      = '0;
                            state_d    = ST_RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.dataValidIn) begin
                        shift_en = 1'b1;
                        shift_re = bus.dataInRe;
                        shift_im = bus.dataInIm;
                        vline_d  = 1'b1;
                    end
                    if (bus.flush) begin
                        fcnt_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    shift_en = 1'b1;
                    vline_d  = 1'b1;
                    if (fcnt_q == FLUSH_LAST) begin
                        fcnt_d  = '0;
                        busy_d  = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        for (int unsigned i = 0; i < LENGTH; i++) begin
            if (line_clear) begin
                line_re_d[i] = '0;
                line_im_d[i] = '0;
            end else if (shift_en) begin
                line_re_d[i] = (i == 0) ? shift_re : line_re_q[i-1];
                line_im_d[i] = (i == 0) ? shift_im : line_im_q[i-1];
            end else begin
                line_re_d[i] = line_re_q[i];
                line_im_d[i] = line_im_q[i];
            end
        end

        sum_re_d = vprod_q ? acc_re : sum_re_q;
        sum_im_d = vprod_q ? acc_im : sum_im_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            fcnt_q    <= '0;
            conj_q    <= 1'b0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            vline_q   <= 1'b0;
            vprod_q   <= 1'b0;
            vout_q    <= 1'b0;
            coef_re_q <= '{default: '0};
            coef_im_q <= '{default: '0};
            line_re_q <= '{default: '0};
            line_im_q <= '{default: '0};
            sum_re_q  <= '0;
            sum_im_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            conj_q    <= conj_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
            vline_q   <= vline_d;
            vprod_q   <= vprod_d;
            vout_q    <= vout_d;
            coef_re_q <= coef_re_d;
            coef_im_q <= coef_im_d;
            line_re_q <= line_re_d;
            line_im_q <= line_im_d;
            sum_re_q  <= sum_re_d;
            sum_im_q  <= sum_im_d;
        end
    end

    assign bus.coeffSetFlag = flag_q;
    assign bus.busy         = busy_q;
    assign bus.dataValidOut = vout_q;
    assign bus.dataOutRe    = sum_re_q;
    assign bus.dataOutIm    = sum_im_q;

endmodule
